fifo_arb: RTL and testbench
===========================

FIFO_ARB -- requirements
Module: fifo_arb

Interface
REQ-001 Parameter N, default 4: number of write requesters, 2..8.
REQ-002 Parameter DW, default 8: data width per entry.
REQ-003 Parameter DEPTH_N, default 4: log2 of FIFO depth, so depth D = 2^DEPTH_N entries.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  N  per-requester write request; bit i belongs to requester i.
REQ-007 wdata  input  N*DW  requester i data on bits [i*DW +: DW].
REQ-008 gnt  output  N  one-hot or zero; bit i high means requester i's wdata is written at this clock edge.
REQ-009 rd_valid  output  1  head entry is available.
REQ-010 rd_data  output  DW  data of the head entry.
REQ-011 rd_src  output  clog2(N)  requester index that wrote the head entry.
REQ-012 rd_ready  input  1  consumer accepts the head entry when rd_valid is high.
REQ-013 level  output  DEPTH_N+1  number of stored entries, 0..D.
REQ-014 empty, full  output  1 each  level==0, level==D.
REQ-015 overrun, underrun  output  1 each  registered error flags.

Function
REQ-016 Storage SHALL be D entries of {src, data}, addressed by DEPTH_N-bit head and tail pointers that wrap modulo D.
REQ-017 Arbitration SHALL be combinational and round-robin, using a registered priority pointer prio (0..N-1).
REQ-018 gnt SHALL select the first i with req[i]=1, searching prio, prio+1, ... modulo N.
REQ-019 gnt SHALL be all-zero when full=1, including cycles where a pop also occurs (no write-through-on-full).
REQ-020 On a grant to index g, entry[tail] SHALL be written with {g, wdata[g]}, tail SHALL advance by 1, and prio SHALL become (g+1) mod N at the same edge.
REQ-021 When there is no grant, prio SHALL hold its value.
REQ-022 rd_valid SHALL equal ~empty; rd_data and rd_src SHALL be the contents of entry[head] with zero-cycle latency.
REQ-023 A pop occurs when rd_valid & rd_ready; head SHALL advance by 1.
REQ-024 Level update rules: push only gives level+1; pop only gives level-1; push and pop in the same cycle leave level unchanged.
REQ-025 Write-to-read latency SHALL be 1 cycle: an entry granted at edge k is visible on rd_data after edge k when the FIFO was empty.
REQ-026 overrun SHALL be registered each cycle as full & (|req): high for exactly the cycle after each refused cycle.
REQ-027 underrun SHALL be registered each cycle as empty & rd_ready.
REQ-028 Pointer wrap from D-1 to 0 SHALL be seamless, with no lost or duplicated entry.
REQ-029 Requesters not granted SHALL see gnt[i]=0 and are expected to hold req and wdata; the block keeps no per-requester state besides prio.

Reset
REQ-030 While reset=1, the block SHALL force the following values asynchronously: head=tail=0, level=0, prio=0, overrun=underrun=0, so empty=1, full=0, rd_valid=0 and gnt=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-032 In the first cycle after reset deassertion, arbitration SHALL start from prio=0.

Verification
REQ-033 Round-robin: N=4, req=4'b1111 held, rd_ready=1 -> gnt sequence 0001,0010,0100,1000,0001; rd_src sequence 0,1,2,3 one cycle later.
REQ-034 Skip idle requesters: prio=1, req=4'b1001 -> gnt=1000 and prio becomes 0; next cycle gnt=0001 and prio becomes 1.
REQ-035 Fill and overrun: D=16, rd_ready=0, req[2]=1 for 17 cycles -> 16 grants, then full=1 and level=16; gnt=0 on the 17th cycle; overrun=1 on the 18th cycle.
REQ-036 Simultaneous push and pop at level=5 -> level stays 5, head and tail both advance; rd_data order equals write order across the tail wrap 15->0.
REQ-037 Underrun and reset: with empty=1 and rd_ready=1 -> underrun=1 next cycle. Reset pulse at level=7 -> level=0, rd_valid=0, prio=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/fifo_arb.sv
// fifo_arb: N-requester round-robin write arbiter feeding a single
// 2^DEPTH_N-entry FIFO. Each entry stores the winning requester's data and
// its index, so the consumer can tell which requester produced each word.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   asynchronous, active-high reset
//   req       in   [N]       per-requester write request
//   wdata     in   [N*DW]    requester i data on [i*DW +: DW]
//   gnt       out  [N]       one-hot/zero; requester written at this edge
//   rd_valid  out            head entry available (= ~empty)
//   rd_data   out  [DW]      head entry data (zero-latency read)
//   rd_src    out  [clog2 N] requester index that wrote the head entry
//   rd_ready  in             consumer accepts head entry
//   level     out  [DEPTH_N+1] number of stored entries, 0..D
//   empty     out            level == 0
//   full      out            level == D
//   overrun   out            registered: previous cycle was full with a request
//   underrun  out            registered: previous cycle was empty with rd_ready
module fifo_arb #(
  parameter int N       = 4,
  parameter int DW      = 8,
  parameter int DEPTH_N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*DW-1:0]      wdata,
  output logic [N-1:0]         gnt,
  output logic                 rd_valid,
  output logic [DW-1:0]        rd_data,
  output logic [$clog2(N)-1:0] rd_src,
  input  logic                 rd_ready,
  output logic [DEPTH_N:0]     level,
  output logic                 empty,
  output logic                 full,
  output logic                 overrun,
  output logic                 underrun
);

  localparam int          SW = $clog2(N);
  localparam int unsigned NU = N;
  localparam int unsigned D  = 1 << DEPTH_N;

  logic [DW-1:0]      r_mem_data [D];
  logic [SW-1:0]      r_mem_src  [D];
  logic [DEPTH_N-1:0] r_head;
  logic [DEPTH_N-1:0] r_tail;
  logic [DEPTH_N:0]   r_level;
  logic [SW-1:0]      r_prio;
  logic               r_overrun;
  logic               r_underrun;

  logic [N-1:0]       w_gnt;
  logic [SW-1:0]      w_gidx;
  logic [SW-1:0]      w_cand;
  logic               w_found;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [SW-1:0]      w_prio_nxt;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == (DEPTH_N+1)'(D));

  // Round-robin search starting at r_prio. The grant is suppressed while
  // full (even if a pop frees a slot this cycle) and while reset is held,
  // so gnt is zero during reset without depending on register state.
  always_comb begin
    w_gnt   = '0;
    w_gidx  = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NU; k++) begin
      w_cand = SW'((32'(r_prio) + k) % NU);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
    if (w_full || reset) begin
      w_found = 1'b0;
    end
    if (w_found) begin
      w_gnt[w_gidx] = 1'b1;
    end
  end

  assign w_push     = w_found;
  assign w_pop      = ~w_empty & rd_ready;
  assign w_prio_nxt = (w_gidx == SW'(N-1)) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_level    <= '0;
      r_prio     <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
        r_prio <= w_prio_nxt;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      r_overrun  <= w_full & (|req);
      r_underrun <= w_empty & rd_ready;
    end
  end

  // Storage is not reset; emptiness is tracked by r_level alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_tail] <= wdata[w_gidx*DW +: DW];
      r_mem_src[r_tail]  <= w_gidx;
    end
  end

  assign gnt      = w_gnt;
  assign rd_valid = ~w_empty;
  assign rd_data  = r_mem_data[r_head];
  assign rd_src   = r_mem_src[r_head];
  assign level    = r_level;
  assign empty    = w_empty;
  assign full     = w_full;
  assign overrun  = r_overrun;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_fifo_arb.sv
module tb_fifo_arb;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int DEPTH_N = 4;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      gnt;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;
  logic [1:0]        rd_src;
  logic              rd_ready;
  logic [DEPTH_N:0]  level;
  logic              empty;
  logic              full;
  logic              overrun;
  logic              underrun;

  int n_cmp;
  int n_err;

  fifo_arb #(.N(N), .DW(DW), .DEPTH_N(DEPTH_N)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .gnt(gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_src(rd_src),
    .rd_ready(rd_ready), .level(level), .empty(empty), .full(full),
    .overrun(overrun), .underrun(underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Pulse reset between edges, leave inputs idle, return just after a posedge.
  task automatic apply_reset();
    req      = '0;
    rd_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    req      = 4'b1111;
    rd_ready = 1'b1;
    wdata    = '0;
    #1;
    reset = 1'b1;
    #1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_cmp++; if ({empty, full, rd_valid} !== 3'b100) begin n_err++; $display("FAIL reset_flags: got %b expected 100", {empty, full, rd_valid}); end
    n_cmp++; if ({overrun, underrun} !== 2'b00) begin n_err++; $display("FAIL reset_err: got %b expected 00", {overrun, underrun}); end
    reset = 1'b0;
    req   = '0;
    rd_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_gnt [5];
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    apply_reset();
    for (int i = 0; i < N; i++) wdata[i*DW +: DW] = 8'(8'h11 * (i + 1));
    req      = 4'b1111;
    rd_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt !== exp_gnt[c]) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, exp_gnt[c]); end
      if (c == 0) begin
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rr_valid0: got %b expected 0", rd_valid); end
      end else begin
        n_cmp++; if (rd_src !== 2'(c - 1)) begin n_err++; $display("FAIL rr_src[%0d]: got %0d expected %0d", c, rd_src, c - 1); end
        n_cmp++; if (rd_data !== 8'(8'h11 * c)) begin n_err++; $display("FAIL rr_data[%0d]: got %h expected %h", c, rd_data, 8'(8'h11 * c)); end
      end
      @(posedge clk);
      #1;
    end
    // Leaves prio=1 and one entry (src 0) queued for test_skip_idle.
  endtask

  task automatic test_skip_idle();
    logic [N-1:0] exp_gnt [3];
    logic [1:0]   exp_src [3];
    exp_gnt[0] = 4'b1000; exp_gnt[1] = 4'b0001; exp_gnt[2] = 4'b1000;
    exp_src[0] = 2'd0;    exp_src[1] = 2'd3;    exp_src[2] = 2'd0;
    req      = 4'b1001;
    rd_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt !== exp_gnt[c]) begin n_err++; $display("FAIL skip_gnt[%0d]: got %b expected %b", c, gnt, exp_gnt[c]); end
      n_cmp++; if (rd_src !== exp_src[c]) begin n_err++; $display("FAIL skip_src[%0d]: got %0d expected %0d", c, rd_src, exp_src[c]); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_fill_overrun();
    apply_reset();
    rd_ready = 1'b0;
    req      = 4'b0100;
    for (int c = 0; c < 17; c++) begin
      wdata[2*DW +: DW] = 8'(8'hA0 + c);
      @(negedge clk);
      if (c < 16) begin
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL fill_gnt[%0d]: got %b expected 0100", c, gnt); end
        n_cmp++; if (level !== 5'(c)) begin n_err++; $display("FAIL fill_level[%0d]: got %0d expected %0d", c, level, c); end
      end else begin
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL full_gnt: got %b expected 0000", gnt); end
        n_cmp++; if ({full, level} !== {1'b1, 5'd16}) begin n_err++; $display("FAIL full_level: got full=%b level=%0d expected full=1 level=16", full, level); end
      end
      n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL fill_overrun[%0d]: got %b expected 0", c, overrun); end
      @(posedge clk);
      #1;
    end
    req = '0;
    @(negedge clk);
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
    for (int d = 0; d < 16; d++) begin
      if (d > 0) @(negedge clk);
      n_cmp++; if ({rd_src, rd_data} !== {2'd2, 8'(8'hA0 + d)}) begin n_err++; $display("FAIL fill_drain[%0d]: got src=%0d data=%h expected src=2 data=%h", d, rd_src, rd_data, 8'(8'hA0 + d)); end
      @(posedge clk);
      #1;
    end
    n_cmp++; if ({empty, level} !== {1'b1, 5'd0}) begin n_err++; $display("FAIL fill_empty: got empty=%b level=%0d expected empty=1 level=0", empty, level); end
  endtask

  task automatic test_push_pop_wrap();
    apply_reset();
    req      = 4'b0001;
    rd_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      wdata[0 +: DW] = 8'(8'h50 + c);
      @(posedge clk);
      #1;
    end
    rd_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      wdata[0 +: DW] = 8'(8'h55 + j);
      @(negedge clk);
      n_cmp++; if (level !== 5'd5) begin n_err++; $display("FAIL pp_level[%0d]: got %0d expected 5", j, level); end
      n_cmp++; if (rd_data !== 8'(8'h50 + j)) begin n_err++; $display("FAIL pp_data[%0d]: got %h expected %h", j, rd_data, 8'(8'h50 + j)); end
      @(posedge clk);
      #1;
    end
    req = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (rd_data !== 8'(8'h60 + i)) begin n_err++; $display("FAIL pp_drain[%0d]: got %h expected %h", i, rd_data, 8'(8'h60 + i)); end
      @(posedge clk);
      #1;
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL pp_empty: got %b expected 1", empty); end
  endtask

  task automatic test_underrun();
    apply_reset();
    rd_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL underrun_pre: got %b expected 0", underrun); end
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_set: got %b expected 1", underrun); end
    @(posedge clk);
    #1;
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL underrun_clear: got %b expected 0", underrun); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req      = 4'b0010;
    rd_ready = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_cmp++; if (level !== 5'd7) begin n_err++; $display("FAIL ar_level_pre: got %0d expected 7", level); end
    reset = 1'b1;
    #1;
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL ar_level: got %0d expected 0", level); end
    n_cmp++; if ({rd_valid, empty} !== 2'b01) begin n_err++; $display("FAIL ar_valid: got valid=%b empty=%b expected valid=0 empty=1", rd_valid, empty); end
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL ar_gnt: got %b expected 0000", gnt); end
    #1;
    reset = 1'b0;
    req   = 4'b1111;
    #1;
    // Before the reset prio had moved to 2; a grant to requester 0 proves it was cleared.
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL ar_prio: got %b expected 0001", gnt); end
    @(posedge clk);
    #1;
    req = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_round_robin();
    test_skip_idle();
    test_fill_overrun();
    test_push_pop_wrap();
    test_underrun();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
